// File: rtl/qlf_iob_pkg.sv
// Shared constants and helpers for the qlf_iob pad bank.
package qlf_iob_pkg;

    localparam int QLF_IOB_WIDTH_DEF     = 8;
    localparam int QLF_IOB_IN_STAGES_DEF = 2;
    localparam int QLF_IOB_TURN_DEF      = 1;

    // Width needed to hold 0..limit inclusive, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/qlf_iob_if.sv
// Fabric-side bus of the pad bank: drive data/enables out, captured data and valid flags back.
interface qlf_iob_if
    import qlf_iob_pkg::*;
#(
    parameter int WIDTH = QLF_IOB_WIDTH_DEF
);
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] o_valid;

    modport master (output i, output t, input o, input o_valid);
    modport slave  (input i, input t, output o, output o_valid);
endinterface

// File: rtl/qlf_iob_cell.sv
// One registered bidirectional pad channel: output/enable registers, input capture pipeline,
// tristate driver and a saturating bus-turnaround counter that qualifies captured data.
module qlf_iob_cell
    import qlf_iob_pkg::*;
#(
    parameter int IN_STAGES   = QLF_IOB_IN_STAGES_DEF,
    parameter int TURN_CYCLES = QLF_IOB_TURN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic lb_en,
    input  logic i,
    input  logic t,
    output logic o,
    output logic o_valid,
    inout  wire  pad
);
    localparam int             LIMIT   = TURN_CYCLES + IN_STAGES;
    localparam int             CW      = cnt_width(LIMIT);
    localparam logic [CW-1:0]  LIMIT_C = CW'(LIMIT);

    logic                 i_r;
    logic                 t_r;
    logic [IN_STAGES-1:0] stage;
    logic [CW-1:0]        cnt;
    logic                 drive;
    logic                 sample;

    // Loopback releases the pad and feeds the output register straight into the capture pipe.
    assign drive  = t_r & ~lb_en;
    assign pad    = drive ? i_r : 1'bz;
    assign sample = lb_en ? i_r : pad;

    always_ff @(posedge clk) begin
        // NOTE: every register here, the capture pipeline included, is cleared by reset so
        // o and o_valid come up at 0 rather than replaying stale pad samples.
        if (rst) begin
            i_r   <= 1'b0;
            t_r   <= 1'b0;
            stage <= '0;
            cnt   <= '0;
        end else if (ce) begin
            // NOTE: non-blocking assignments let stage[n] take the pre-edge stage[n-1]
            // regardless of statement order, which is what makes this a shift register.
            i_r      <= i;
            t_r      <= t;
            stage[0] <= sample;
            for (int n = 1; n < IN_STAGES; n++) begin
                stage[n] <= stage[n-1];
            end
            if (drive) begin
                cnt <= '0;
            end else if (cnt != LIMIT_C) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign o       = stage[IN_STAGES-1];
    assign o_valid = (cnt == LIMIT_C);

endmodule

// File: rtl/qlf_iob_bank.sv
// WIDTH independent registered IOB channels sharing clk/rst/ce.
// Optional fabric-side loopback self-test enabled by defining QLF_IOB_LOOPBACK_EN.
module qlf_iob_bank
    import qlf_iob_pkg::*;
#(
    parameter int WIDTH       = QLF_IOB_WIDTH_DEF,
    parameter int IN_STAGES   = QLF_IOB_IN_STAGES_DEF,
    parameter int TURN_CYCLES = QLF_IOB_TURN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
`ifdef QLF_IOB_LOOPBACK_EN
    input  logic             lb_en,
`endif
    qlf_iob_if.slave         bus,
    inout  wire  [WIDTH-1:0] pad
);
    logic             lb_sel;
    logic [WIDTH-1:0] o_w;
    logic [WIDTH-1:0] o_valid_w;

`ifdef QLF_IOB_LOOPBACK_EN
    assign lb_sel = lb_en;
`else
    assign lb_sel = 1'b0;
`endif

    for (genvar k = 0; k < WIDTH; k++) begin : g_ch
        qlf_iob_cell #(
            .IN_STAGES   (IN_STAGES),
            .TURN_CYCLES (TURN_CYCLES)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .lb_en   (lb_sel),
            .i       (bus.i[k]),
            .t       (bus.t[k]),
            .o       (o_w[k]),
            .o_valid (o_valid_w[k]),
            .pad     (pad[k])
        );
    end

    assign bus.o       = o_w;
    assign bus.o_valid = o_valid_w;

endmodule

// File: tb/tb_qlf_iob_bank.sv
// Directed plus randomized bench for qlf_iob_bank against a per-edge behavioural model.
module tb_qlf_iob_bank;
    import qlf_iob_pkg::*;

    localparam int W     = QLF_IOB_WIDTH_DEF;
    localparam int S     = QLF_IOB_IN_STAGES_DEF;
    localparam int TC    = QLF_IOB_TURN_DEF;
    localparam int LIMIT = TC + S;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    logic lb_val = 1'b0;

    logic [W-1:0] ext_en   = '1;
    logic [W-1:0] ext_data = '0;
    wire  [W-1:0] pad;

    int checks = 0;
    int errors = 0;

    // Model state: what the design should hold after each edge.
    logic [W-1:0] m_i_r = '0;
    logic [W-1:0] m_t_r = '0;
    logic [W-1:0] m_pipe [S];
    int           m_released [W];

    qlf_iob_if #(.WIDTH(W)) bus ();

    qlf_iob_bank #(
        .WIDTH       (W),
        .IN_STAGES   (S),
        .TURN_CYCLES (TC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
`ifdef QLF_IOB_LOOPBACK_EN
        .lb_en (lb_val),
`endif
        .bus   (bus),
        .pad   (pad)
    );

    for (genvar k = 0; k < W; k++) begin : g_ext
        assign pad[k] = ext_en[k] ? ext_data[k] : 1'bz;
    end

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_drive();
        return lb_val ? '0 : m_t_r;
    endfunction

    function automatic logic [W-1:0] model_pad();
        logic [W-1:0] drv;
        drv = model_drive();
        return (drv & m_i_r) | (~drv & ext_data);
    endfunction

    function automatic logic [W-1:0] model_valid();
        logic [W-1:0] v;
        for (int k = 0; k < W; k++) v[k] = (m_released[k] >= LIMIT);
        return v;
    endfunction

    // The external driver always fills exactly the bits the design leaves released.
    task automatic upd_ext();
        ext_en = ~model_drive();
    endtask

    task automatic set_lb(input logic v);
        lb_val = v;
        upd_ext();
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pad"},     pad,         model_pad());
        check({tag, ".o"},       bus.o,       m_pipe[S-1]);
        check({tag, ".o_valid"}, bus.o_valid, model_valid());
    endtask

    // One clock edge: advance the model with the pre-edge inputs, then compare.
    task automatic step(input string tag);
        logic [W-1:0] pad_pre;
        logic [W-1:0] samp;
        pad_pre = model_pad();
        samp    = lb_val ? m_i_r : pad_pre;
        @(posedge clk);
        if (rst) begin
            m_i_r = '0;
            m_t_r = '0;
            for (int n = 0; n < S; n++) m_pipe[n] = '0;
            for (int k = 0; k < W; k++) m_released[k] = 0;
        end else if (ce) begin
            for (int k = 0; k < W; k++) begin
                if (model_drive() & (W'(1) << k)) m_released[k] = 0;
                else if (m_released[k] < LIMIT) m_released[k]++;
            end
            for (int n = S - 1; n > 0; n--) m_pipe[n] = m_pipe[n-1];
            m_pipe[0] = samp;
            m_t_r = bus.t;
            m_i_r = bus.i;
        end
        #1 upd_ext();
        #1 check_all(tag);
    endtask

    initial begin
        for (int n = 0; n < S; n++) m_pipe[n] = '0;
        for (int k = 0; k < W; k++) m_released[k] = 0;
        bus.i    = 8'hA5;
        bus.t    = 8'hFF;
        ext_data = 8'h96;
        upd_ext();

        // Reset with all pads requested to drive: pads must stay released.
        rst = 1'b1;
        step("rst0");
        step("rst1");
        check("rst.pad_released", pad, 8'h96);
        check("rst.o", bus.o, 8'h00);
        check("rst.o_valid", bus.o_valid, 8'h00);

        rst = 1'b0;
        step("post_rst");
        check("post_rst.pad", pad, 8'hA5);

        // Drive echo: own output data reappears on o after 1+IN_STAGES edges.
        bus.i = 8'h3C;
        for (int n = 0; n < 3; n++) step("echo");
        check("echo.o", bus.o, 8'h3C);
        check("echo.o_valid", bus.o_valid, 8'h00);

        // Release and receive.
        bus.t    = 8'h00;
        ext_data = 8'h5A;
        step("rel_e0");
        step("rel_e1");
        step("rel_e2");
        check("rel_e2.o_valid", bus.o_valid, 8'h00);
        step("rel_e3");
        check("rel_e3.o_valid", bus.o_valid, 8'hFF);
        check("rel_e3.o", bus.o, 8'h5A);

        // Re-drive bit 0 only.
        bus.t = 8'h01;
        step("redrv_e");
        check("redrv_e.o_valid", bus.o_valid, 8'hFF);
        step("redrv_e1");
        check("redrv_e1.o_valid", bus.o_valid, 8'hFE);

        // Clock-enable hold mid-count.
        bus.t = 8'hFF;
        step("ce_drv0");
        step("ce_drv1");
        bus.t = 8'h00;
        ext_data = 8'h81;
        step("ce_e0");
        step("ce_e1");
        ce = 1'b0;
        for (int n = 0; n < 5; n++) begin
            ext_data = 8'($urandom);
            step("ce_hold");
        end
        check("ce_hold.o_valid", bus.o_valid, 8'h00);
        ce = 1'b1;
        ext_data = 8'h81;
        step("ce_re1");
        check("ce_re1.o_valid", bus.o_valid, 8'h00);
        step("ce_re2");
        check("ce_re2.o_valid", bus.o_valid, 8'hFF);

`ifdef QLF_IOB_LOOPBACK_EN
        // Loopback self-test from a clean reset.
        rst = 1'b1;
        step("lb_rst");
        rst = 1'b0;
        bus.t = 8'hFF;
        bus.i = 8'hC3;
        set_lb(1'b1);
        ext_data = 8'h00;
        for (int n = 0; n < 3; n++) step("lb");
        check("lb.pad_released", pad, 8'h00);
        check("lb.o", bus.o, 8'hC3);
        check("lb.o_valid", bus.o_valid, 8'hFF);
        set_lb(1'b0);
`endif

        // Randomized traffic with sparse per-bit direction changes.
        for (int n = 0; n < 400; n++) begin
            bus.i    = 8'($urandom);
            bus.t    = bus.t ^ (8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom));
            ext_data = 8'($urandom);
            ce       = ($urandom_range(0, 99) < 85);
            rst      = ($urandom_range(0, 99) < 2);
`ifdef QLF_IOB_LOOPBACK_EN
            if ($urandom_range(0, 99) < 3) set_lb(~lb_val);
`endif
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
